uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised async-serial transmitter with input FIFO. Buffers up to
//   FIFO_DEPTH characters from the text generator and sends them back-to-back
//   as start / data (LSB first) / optional parity / stop frames at BAUD.
//   Drives the board TX pin and replaces the fixed 7N1, 9600-baud sender.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock frequency, Hz
//   BAUD       9600        line rate; DIVISOR = CLK_HZ/BAUD (integer divide, >=2)
//   DATA_BITS  7           data bits per frame, legal 5..8
//   PARITY     0           0 = none, 1 = even, 2 = odd
//   STOP_BITS  1           1 or 2
//   FIFO_DEPTH 4           entries, power of 2, >=2; AW = $clog2(FIFO_DEPTH)
// PORTS
//   clk    in   1     system clock, all logic on rising edge
//   rst_n  in   1     reset, asynchronous, active-low
//   data   in   8     character; bits above DATA_BITS-1 ignored
//   send   in   1     write request; accepted on an edge where send && ready
//   ready  out  1     FIFO not full
//   out    out  1     serial line; MARK = 1, SPACE = 0
//   busy   out  1     FIFO non-empty or frame in progress
//   done   out  1     one-cycle pulse on completion of each frame
//   level  out  AW+1  current FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
// - Reset (async assert, sync release): out=1, ready=1, busy=0, done=0,
//   level=0, FSM=IDLE, FIFO pointers and bit/baud counters cleared. Reset
//   mid-frame aborts the frame immediately; no partial frame resumes.
// - FIFO: write on send&&ready; pop only by FSM. Simultaneous write and pop:
//   level unchanged. Write while full is dropped (ready=0 warns sender).
// - FSM states IDLE, START, DATA, PAR, STOP. out is registered.
//   IDLE: out=1; if level!=0, pop head into shift reg, go START.
//   START: out=0 for DIVISOR cycles -> DATA.
//   DATA: out=shift[0], shift right each bit; after DATA_BITS bits ->
//     PAR if PARITY!=0 else STOP.
//   PAR: out = ^data (even) or ~^data (odd), DIVISOR cycles -> STOP.
//   STOP: out=1 for STOP_BITS*DIVISOR cycles; on last cycle done=1 and,
//     if level!=0, pop and go directly to START (no idle gap), else IDLE.
// - Every bit lasts exactly DIVISOR clocks; baud counter 0..DIVISOR-1 wraps
//   and restarts at 0 on each state entry.
// - Latency: send accepted at edge N into empty FIFO, FSM IDLE -> out falls
//   at edge N+2.
// - Frame cycles = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIVISOR.
// - busy = (state!=IDLE) || (level!=0); falls the edge after final done.
// - Illegal parameter values: $error at elaboration.
// TESTING (CLK_HZ=40, BAUD=10 -> DIVISOR=4 unless noted)
// 1 7N1, send 0x41 once -> out: 0 x4, bits 1,0,0,0,0,0,1 x4 each, 1 x4;
//   done one pulse exactly 36 cycles after out falls; busy low next cycle.
// 2 8E1 send 0x03 -> parity bit 0; 8O1 send 0x03 -> parity bit 1; 8E1
//   send 0x07 -> parity 1; frame 44 cycles.
// 3 DEPTH=4, hold send 6 cycles with 0x30..0x35 -> ready drops at level 4,
//   rejected word absent; accepted words sent in order, no gap between frames.
// 4 7N2, send 0x55 -> stop high 8 cycles before next start; done at end of
//   second stop bit only.
// 5 Assert rst_n=0 mid-DATA with 2 queued -> out=1 same cycle without clk,
//   level=0, busy=0, ready=1; after release send 0x2A -> clean frame.
// 6 Write on same edge as FSM pop at level 1 -> level stays 1, no data lost.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Async-serial transmitter with a small input FIFO: start / data (LSB first) /
// optional parity / stop frames at CLK_HZ/BAUD clocks per bit, sent back-to-back.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 7,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data,
    input  logic                          send,
    output logic                          ready,
    output logic                          out,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int unsigned DIVISOR = CLK_HZ / BAUD;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned CW      = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
    localparam int unsigned BW      = 3;

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx_fifo: CLK_HZ/BAUD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   ready_q, out_q, out_d, busy_q, done_q;
    logic                   stop_end_q, stop_end_d;
    logic                   accept, pop, baud_last;
    logic [DATA_BITS-1:0]   head;
    logic                   unused_data;

    assign unused_data = ^data;
    assign accept      = send && ready_q;
    assign head        = mem_q[rd_ptr_q];
    assign baud_last   = (baud_q == CW'(DIVISOR - 1));
    assign wr_ptr_d    = wr_ptr_q + AW'(accept);
    assign rd_ptr_d    = rd_ptr_q + AW'(pop);
    assign level_d     = level_q + LW'(accept) - LW'(pop);

    // Storage carries no reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= data[DATA_BITS-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_last ? '0 : baud_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;
        stop_end_d = 1'b0;
        out_d      = 1'b1;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                out_d = 1'b0;
                if (baud_last) state_d = S_DATA;
            end
            S_DATA: begin
                out_d = shift_q[0];
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PAR: begin
                out_d = par_q;
                if (baud_last) state_d = S_STOP;
            end
            S_STOP: begin
                if (baud_last) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        stop_end_d = 1'b1;
                        bit_d      = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shift_d = head;
            par_d   = (PARITY == 2) ? ~^head : ^head;
        end
    end

    // Line, done and busy trail the FSM by one clock so they stay bit-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stop_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= (level_d != LW'(FIFO_DEPTH));
            out_q      <= out_d;
            busy_q     <= (state_q != S_IDLE) || (level_q != '0) || stop_end_q;
            done_q     <= stop_end_q;
            stop_end_q <= stop_end_d;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (7N1, 8E1, 8O1, 7N2) at DIVISOR=4,
// a line monitor per instance checking frames against a queue of sent words.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] send_a = '0;
    logic [7:0] data_a [4];
    logic [3:0] ready_a, out_a, busy_a, done_a;
    logic [2:0] lvl_a [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(data_a[0]), .send(send_a[0]), .ready(ready_a[0]),
        .out(out_a[0]), .busy(busy_a[0]), .done(done_a[0]), .level(lvl_a[0]));
    uart_tx_fifo #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data_a[1]), .send(send_a[1]), .ready(ready_a[1]),
        .out(out_a[1]), .busy(busy_a[1]), .done(done_a[1]), .level(lvl_a[1]));
    uart_tx_fifo #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data(data_a[2]), .send(send_a[2]), .ready(ready_a[2]),
        .out(out_a[2]), .busy(busy_a[2]), .done(done_a[2]), .level(lvl_a[2]));
    uart_tx_fifo #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .data(data_a[3]), .send(send_a[3]), .ready(ready_a[3]),
        .out(out_a[3]), .busy(busy_a[3]), .done(done_a[3]), .level(lvl_a[3]));

    function automatic void check(string name, int k, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=0x%0h expected=0x%0h t=%0t", name, k, got, exp, $time);
        end
    endfunction

    function automatic int cfg_nb(int k);   return (k == 1 || k == 2) ? 8 : 7; endfunction
    function automatic int cfg_par(int k);  return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
    function automatic int cfg_stop(int k); return (k == 3) ? 2 : 1; endfunction

    // Expected line bits of one frame, index 0 = start bit; unused upper bits are MARK.
    function automatic logic [15:0] frame_bits(int k, logic [7:0] d);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < cfg_nb(k); i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (cfg_par(k) == 1) f[1 + cfg_nb(k)] = p;
        if (cfg_par(k) == 2) f[1 + cfg_nb(k)] = ~p;
        return f;
    endfunction

    function automatic void q_push(int k, logic [7:0] d);
        case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endfunction

    function automatic int q_size(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [7:0] q_pop(int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic void q_clear(int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            2: q2.delete();
            default: q3.delete();
        endcase
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_mon
        int b2b = 0;
        initial begin
            logic [15:0] fb;
            logic [3:0]  samp;
            int          s, nbt;
            bit          act, ended, dbad;
            act = 1'b0;
            s   = 0;
            nbt = 1 + cfg_nb(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_stop(k);
            fb  = '1;
            samp = '0;
            dbad = 1'b0;
            forever begin
                @(negedge clk);
                ended = 1'b0;
                if (!rst_n) begin
                    act = 1'b0;
                end else begin
                    if (act && s == 4 * nbt) begin
                        check("done_at_frame_end", k, 32'(done_a[k]), 32'd1);
                        check("done_inside_frame", k, 32'(dbad), 32'd0);
                        act   = 1'b0;
                        ended = 1'b1;
                    end
                    if (!act && out_a[k] === 1'b0) begin
                        if (ended) b2b++;
                        if (q_size(k) == 0) begin
                            check("unexpected_frame", k, 32'd1, 32'd0);
                            fb = frame_bits(k, 8'h00);
                        end else begin
                            fb = frame_bits(k, q_pop(k));
                        end
                        act  = 1'b1;
                        s    = 0;
                        dbad = 1'b0;
                    end
                    if (act) begin
                        samp[s % 4] = out_a[k];
                        if (s > 0 && done_a[k] !== 1'b0) dbad = 1'b1;
                        if (s % 4 == 3) begin
                            check($sformatf("line_bit%0d", s / 4), k, 32'(samp), 32'({4{fb[s / 4]}}));
                        end
                        s++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(int k, logic [7:0] d);
        send_a[k] = 1'b1;
        data_a[k] = d;
        q_push(k, d);
        tick();
        send_a[k] = 1'b0;
    endtask

    task automatic wait_idle(int k, int budget);
        int c;
        c = 0;
        tick();
        tick();
        while (busy_a[k] && c < budget) begin
            tick();
            c++;
        end
        check("wait_idle_timeout", k, 32'(busy_a[k]), 32'd0);
    endtask

    typedef struct {
        logic       send;
        logic [7:0] data;
        int         lvl;
        logic       rdy;
        logic       acc;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, b0;
        tbl[0] = '{1'b1, 8'h30, 1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 8'h31, 1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 8'h32, 2, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h33, 3, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 8'h34, 4, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 8'h35, 4, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) data_a[k] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("rst_out",   k, 32'(out_a[k]),   32'd1);
            check("rst_ready", k, 32'(ready_a[k]), 32'd1);
            check("rst_busy",  k, 32'(busy_a[k]),  32'd0);
            check("rst_done",  k, 32'(done_a[k]),  32'd0);
            check("rst_level", k, 32'(lvl_a[k]),   32'd0);
        end
        tick();

        // 7N1 single frame: latency, done timing, busy release.
        send_word(0, 8'h41);
        check("t1_out_edgeN", 0, 32'(out_a[0]), 32'd1);
        tick();
        check("t1_out_edgeN1", 0, 32'(out_a[0]), 32'd1);
        tick();
        check("t1_out_edgeN2", 0, 32'(out_a[0]), 32'd0);
        c = 0;
        while (!done_a[0] && c < 60) begin
            tick();
            c++;
        end
        check("t1_done_delay", 0, 32'(c), 32'd36);
        tick();
        check("t1_done_pulse", 0, 32'(done_a[0]), 32'd0);
        check("t1_busy_after", 0, 32'(busy_a[0]), 32'd0);
        tick();

        // FIFO fill with send held: level/ready per edge, overflow word dropped.
        b0 = g_mon[0].b2b;
        for (int i = 0; i < 6; i++) begin
            send_a[0] = tbl[i].send;
            data_a[0] = tbl[i].data;
            if (tbl[i].acc) q_push(0, tbl[i].data);
            tick();
            check($sformatf("t3_level_%0d", i), 0, 32'(lvl_a[0]),   32'(tbl[i].lvl));
            check($sformatf("t3_ready_%0d", i), 0, 32'(ready_a[0]), 32'(tbl[i].rdy));
        end
        send_a[0] = 1'b0;
        wait_idle(0, 400);
        check("t3_back_to_back", 0, 32'(g_mon[0].b2b - b0), 32'd4);

        // Parity frames: 8E1 0x03, 8E1 0x07, 8O1 0x03.
        send_word(1, 8'h03);
        wait_idle(1, 100);
        send_word(1, 8'h07);
        wait_idle(1, 100);
        send_word(2, 8'h03);
        wait_idle(2, 100);

        // 7N2: two stop bits between back-to-back frames.
        b0 = g_mon[3].b2b;
        send_word(3, 8'h55);
        send_word(3, 8'h55);
        wait_idle(3, 200);
        check("t4_back_to_back", 3, 32'(g_mon[3].b2b - b0), 32'd1);

        // Write coinciding with pops: from IDLE and from the last STOP cycle.
        b0 = g_mon[1].b2b;
        send_word(1, 8'h5A);
        send_word(1, 8'hA5);
        check("t6_level_idle_pop", 1, 32'(lvl_a[1]), 32'd1);
        tick();
        check("t6_out_fall", 1, 32'(out_a[1]), 32'd0);
        repeat (42) tick();
        check("t6_level_pre", 1, 32'(lvl_a[1]), 32'd1);
        send_word(1, 8'hC3);
        check("t6_level_stop_pop", 1, 32'(lvl_a[1]), 32'd1);
        wait_idle(1, 300);
        check("t6_back_to_back", 1, 32'(g_mon[1].b2b - b0), 32'd2);

        // Reset mid-DATA with two words queued, then a clean frame.
        send_word(0, 8'h00);
        send_word(0, 8'h11);
        send_word(0, 8'h22);
        repeat (10) tick();
        check("t5_out_before", 0, 32'(out_a[0]), 32'd0);
        check("t5_level_before", 0, 32'(lvl_a[0]), 32'd2);
        #2;
        rst_n = 1'b0;
        q_clear(0);
        #1;
        check("t5_out_async",   0, 32'(out_a[0]),   32'd1);
        check("t5_level_async", 0, 32'(lvl_a[0]),   32'd0);
        check("t5_busy_async",  0, 32'(busy_a[0]),  32'd0);
        check("t5_ready_async", 0, 32'(ready_a[0]), 32'd1);
        check("t5_done_async",  0, 32'(done_a[0]),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_word(0, 8'h2A);
        wait_idle(0, 100);
        tick();

        for (int k = 0; k < 4; k++) begin
            check("queue_drained", k, 32'(q_size(k)), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
